pixel_compositor: RTL and testbench
===================================

Name: pixel_compositor

Overview:
- Pipelined, parametrised successor to the single-cycle colour mapper.
- Merges NUM_LAYERS sprite/text palette-index layers with the tiled background map, resolves priority, performs a registered palette lookup, and applies blanking.
- Adds a frame-synchronous fade-out / map-swap / fade-in sequencer driven by a request/acknowledge handshake.
- Sits between the sprite engines and the VGA DAC outputs.

Parameters:
- NUM_LAYERS, 4: number of sprite/text index layers; layer 0 has the highest priority.
- IDX_W, 6: palette index width; index 0 is transparent.
- MAP_RANK, 1: layers with index < MAP_RANK draw above the map; all others draw below it.
- NUM_MAPS, 4: number of selectable background maps.
- TILE_LOG2, 4: tile edge is 2^TILE_LOG2 pixels.
- TILES_PER_ROW, 40: tiles per screen row.
- FADE_LOG2, 3: fade has 2^FADE_LOG2 brightness steps.

Ports:
- Clk  in  1  pixel clock.
- Reset  in  1  synchronous, active-high.
- Blank  in  1  1 = active video, 0 = blanking.
- FrameStart  in  1  one-cycle pulse per frame.
- DrawX  in  10  current pixel X coordinate.
- DrawY  in  10  current pixel Y coordinate.
- LayerIdx  in  NUM_LAYERS*IDX_W  packed palette indices; layer k occupies bits [k*IDX_W +: IDX_W].
- MapReq  in  1  request a map change.
- MapSel  in  $clog2(NUM_MAPS)  requested map; sampled when MapAck is asserted.
- MapAck  out  1  one-cycle pulse when a request is accepted.
- Busy  out  1  high while a fade sequence is in progress.
- CurMap  out  $clog2(NUM_MAPS)  map currently displayed.
- Red  out  8  red DAC value.
- Green  out  8  green DAC value.
- Blue  out  8  blue DAC value.

Behaviour:
- Reset values:
  - Red, Green, Blue = 0.
  - MapAck = 0, Busy = 0, CurMap = 0.
  - Fade level = 2^FADE_LOG2 (full brightness).
  - FSM = IDLE.
  - All pipeline registers cleared.
- Pipeline latency is 3 Clk from inputs to RGB. Blank is delayed by the same 3 stages.
  - S1: register all inputs; compute tile index = CurMap*(TILES_PER_ROW*rows) + TILES_PER_ROW*tileY + tileX, where rows = 480>>TILE_LOG2; index width is 11 bits minimum.
  - S2: map ROM returns the map index; priority resolve. Winner is the first non-zero index among layers 0..MAP_RANK-1, then the map index, then layers MAP_RANK..NUM_LAYERS-1. If all are zero, the result is palette index 0.
  - S3: registered palette read; scale each channel as (c*level)>>FADE_LOG2 using 8+FADE_LOG2+1-bit intermediates; force 0 if delayed Blank = 0.
- FSM transitions:
  - IDLE: MapReq=1 and MapSel != CurMap → pulse MapAck, latch MapSel, go to FADE_OUT, Busy=1. MapReq with MapSel == CurMap → MapAck pulse, stay IDLE.
  - FADE_OUT: on each FrameStart, level decrements; at level 0 → SWAP.
  - SWAP: on the next FrameStart, CurMap is set to the latched map → FADE_IN.
  - FADE_IN: on each FrameStart, level increments; at 2^FADE_LOG2 → IDLE, Busy=0.
- Boundary rules:
  - MapReq while Busy is ignored: no MapAck is issued and the request is not queued.
  - The CurMap change happens only at a FrameStart, so a frame never shows two maps.
  - FrameStart coincident with MapReq in IDLE: accept the request; the first decrement occurs on the next FrameStart.
  - Reset mid-fade restores full brightness and map 0 on the next cycle.
  - Level saturates: never below 0 and never above 2^FADE_LOG2.

Optional Feature:
- Macro: TILE_GRID_EN.
- When defined, pixels with DrawX[TILE_LOG2-1:0]==0 or DrawY[TILE_LOG2-1:0]==0 take palette index GRID_IDX (package constant, 6'd1). This applies above the map but below layers < MAP_RANK.
- When undefined, no grid logic is present and behaviour is as above.

Decomposition:
- Package compositor_pkg holds:
  - fade_state_t enum (IDLE, FADE_OUT, SWAP, FADE_IN).
  - GRID_IDX.
  - SCREEN_W=640 and SCREEN_H=480.
  - TRANSPARENT=0.
- Sub-module fade_sequencer owns the FSM, level counter, MapReq/MapAck and CurMap. The top level holds the pipeline, priority resolve, map_rom and palette_rom (registered-output variants).

Test Plan:
- Reset, then all layers=0, map tile index 5, Blank=1 → after 3 Clk, RGB = palette[5] at full level; Blank=0 → RGB=0 with the same 3-cycle lag.
- MAP_RANK=1: layer0=0, layer1=9, map=5 → palette[5]; layer0=7 → palette[7]; map index 0 with layer1=9 → palette[9].
- MapReq, MapSel=2 in IDLE → MapAck pulses once; Busy=1; 8 FrameStarts take level to 0; CurMap=2 at the 9th; 8 more FrameStarts restore full level; Busy=0.
- palette 0xFF8040 at level 4 (FADE_LOG2=3) → RGB 0x7F,0x40,0x20.
- MapReq during FADE_OUT → no MapAck and the target map is unchanged; MapReq with MapSel==CurMap in IDLE → MapAck pulses, Busy stays 0.
- Reset asserted at level 3 in FADE_IN → next cycle CurMap=0, Busy=0, full brightness; with TILE_GRID_EN, DrawX=32 → palette[1] unless layer0 ≠ 0.

Source files
------------

// File: rtl/pixel_compositor_pkg.sv
// rtl/pixel_compositor_pkg.sv - shared types, screen constants and palette contents for pixel_compositor
package compositor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_t;

  localparam logic [5:0] GRID_IDX    = 6'd1;
  localparam int         SCREEN_W    = 640;
  localparam int         SCREEN_H    = 480;
  localparam int         TRANSPARENT = 0;

  // Palette contents: a few fixed colours, the rest derived from the index bits.
  function automatic logic [23:0] palette_rgb(input logic [7:0] idx);
    logic [23:0] rgb;
    case (idx)
      8'd0:    rgb = 24'h000000;
      8'd1:    rgb = 24'h00FF00;
      8'd5:    rgb = 24'hFF8040;
      8'd7:    rgb = 24'h102030;
      8'd9:    rgb = 24'hA0B0C0;
      default: rgb = {idx[5:0], 2'b01, ~idx[5:0], 2'b10, idx[3:0], idx[3:0]};
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/pixel_compositor_fade.sv
// rtl/pixel_compositor_fade.sv - fade_sequencer: frame-synchronous fade-out / map-swap / fade-in control
module fade_sequencer
  import compositor_pkg::*;
#(
  parameter int NUM_MAPS  = 4,
  parameter int FADE_LOG2 = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_start,
  input  logic                        map_req,
  input  logic [$clog2(NUM_MAPS)-1:0] map_sel,
  output logic                        map_ack,
  output logic                        busy,
  output logic [$clog2(NUM_MAPS)-1:0] cur_map,
  output logic [FADE_LOG2:0]          level
);

  localparam int                 LVL_W = FADE_LOG2 + 1;
  localparam int                 MAP_W = $clog2(NUM_MAPS);
  localparam logic [LVL_W-1:0]   FULL  = LVL_W'(1 << FADE_LOG2);

  fade_state_t      state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [MAP_W-1:0] cur_map_q, cur_map_d;
  logic [MAP_W-1:0] target_q, target_d;
  logic             ack_q, ack_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      level_q   <= FULL;
      cur_map_q <= '0;
      target_q  <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      level_q   <= level_d;
      cur_map_q <= cur_map_d;
      target_q  <= target_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (map_req && (map_sel != cur_map_q)) state_d = FADE_OUT;
      FADE_OUT: if (frame_start && (level_q <= LVL_W'(1))) state_d = SWAP;
      SWAP:     if (frame_start) state_d = FADE_IN;
      FADE_IN:  if (frame_start && (level_q >= FULL - LVL_W'(1))) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Requests are only seen in IDLE, so anything arriving mid-fade is dropped.
  always_comb begin
    level_d   = level_q;
    cur_map_d = cur_map_q;
    target_d  = target_q;
    ack_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (map_req) begin
          ack_d    = 1'b1;
          target_d = map_sel;
        end
      end
      FADE_OUT: if (frame_start && (level_q != '0)) level_d = level_q - LVL_W'(1);
      SWAP:     if (frame_start) cur_map_d = target_q;
      FADE_IN:  if (frame_start && (level_q != FULL)) level_d = level_q + LVL_W'(1);
      default:  level_d = FULL;
    endcase
  end

  assign map_ack = ack_q;
  assign busy    = (state_q != IDLE);
  assign cur_map = cur_map_q;
  assign level   = level_q;

endmodule

// File: rtl/pixel_compositor.sv
// rtl/pixel_compositor.sv - 3-stage layer/map compositor with palette lookup and fade; TILE_GRID_EN adds a tile grid overlay
module pixel_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS    = 4,
  parameter int IDX_W         = 6,
  parameter int MAP_RANK      = 1,
  parameter int NUM_MAPS      = 4,
  parameter int TILE_LOG2     = 4,
  parameter int TILES_PER_ROW = 40,
  parameter int FADE_LOG2     = 3
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        Blank,
  input  logic                        FrameStart,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  input  logic [NUM_LAYERS*IDX_W-1:0] LayerIdx,
  input  logic                        MapReq,
  input  logic [$clog2(NUM_MAPS)-1:0] MapSel,
  output logic                        MapAck,
  output logic                        Busy,
  output logic [$clog2(NUM_MAPS)-1:0] CurMap,
  output logic [7:0]                  Red,
  output logic [7:0]                  Green,
  output logic [7:0]                  Blue
);

  localparam int ROWS       = SCREEN_H >> TILE_LOG2;
  localparam int TX_W       = $clog2(SCREEN_W >> TILE_LOG2);
  localparam int TY_W       = $clog2(ROWS);
  localparam int TILE_W_RAW = $clog2(NUM_MAPS * TILES_PER_ROW * ROWS);
  localparam int TILE_W     = (TILE_W_RAW < 11) ? 11 : TILE_W_RAW;
  localparam int PROD_W     = 8 + FADE_LOG2 + 1;
  localparam int LW         = NUM_LAYERS * IDX_W;

  localparam logic [TILE_W-1:0] MAP_STRIDE = TILE_W'(TILES_PER_ROW * ROWS);
  localparam logic [TILE_W-1:0] ROW_STRIDE = TILE_W'(TILES_PER_ROW);

  logic [$clog2(NUM_MAPS)-1:0] cur_map;
  logic [FADE_LOG2:0]          level;

  fade_sequencer #(
    .NUM_MAPS  (NUM_MAPS),
    .FADE_LOG2 (FADE_LOG2)
  ) u_fade (
    .clk         (Clk),
    .reset       (Reset),
    .frame_start (FrameStart),
    .map_req     (MapReq),
    .map_sel     (MapSel),
    .map_ack     (MapAck),
    .busy        (Busy),
    .cur_map     (cur_map),
    .level       (level)
  );

  assign CurMap = cur_map;

  logic [TILE_W-1:0] tile_d;
  assign tile_d = TILE_W'(cur_map) * MAP_STRIDE
                + TILE_W'(DrawY[TILE_LOG2 +: TY_W]) * ROW_STRIDE
                + TILE_W'(DrawX[TILE_LOG2 +: TX_W]);

  logic              s1_blank;
  logic [LW-1:0]     s1_layers;
  logic [TILE_W-1:0] s1_tile;
  logic              s2_blank;
  logic [LW-1:0]     s2_layers;
  logic [IDX_W-1:0]  map_q;
  logic              s3_blank;
  logic [23:0]       pal_q;
  logic [IDX_W-1:0]  win_idx;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_blank  <= 1'b0;
      s1_layers <= '0;
      s1_tile   <= '0;
    end else begin
      s1_blank  <= Blank;
      s1_layers <= LayerIdx;
      s1_tile   <= tile_d;
    end
  end

  // Map ROM (registered output) alongside the stage-2 copies of layers and blank.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      map_q     <= '0;
      s2_blank  <= 1'b0;
      s2_layers <= '0;
    end else begin
      map_q     <= s1_tile[IDX_W-1:0];
      s2_blank  <= s1_blank;
      s2_layers <= s1_layers;
    end
  end

`ifdef TILE_GRID_EN
  logic s1_grid, s2_grid;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_grid <= 1'b0;
      s2_grid <= 1'b0;
    end else begin
      s1_grid <= (DrawX[TILE_LOG2-1:0] == '0) || (DrawY[TILE_LOG2-1:0] == '0);
      s2_grid <= s1_grid;
    end
  end
`endif

  logic unused_bits;
  assign unused_bits = ^{DrawX, DrawY, s1_tile};

  // Walk from lowest to highest priority so later hits override earlier ones.
  always_comb begin
    win_idx = IDX_W'(TRANSPARENT);
    for (int k = NUM_LAYERS - 1; k >= MAP_RANK; k--) begin
      if (s2_layers[k*IDX_W +: IDX_W] != IDX_W'(TRANSPARENT)) win_idx = s2_layers[k*IDX_W +: IDX_W];
    end
    if (map_q != IDX_W'(TRANSPARENT)) win_idx = map_q;
`ifdef TILE_GRID_EN
    if (s2_grid) win_idx = IDX_W'(GRID_IDX);
`endif
    for (int k = MAP_RANK - 1; k >= 0; k--) begin
      if (s2_layers[k*IDX_W +: IDX_W] != IDX_W'(TRANSPARENT)) win_idx = s2_layers[k*IDX_W +: IDX_W];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pal_q    <= '0;
      s3_blank <= 1'b0;
    end else begin
      pal_q    <= palette_rgb(8'(win_idx));
      s3_blank <= s2_blank;
    end
  end

  function automatic logic [7:0] scale(input logic [7:0] c, input logic [FADE_LOG2:0] lvl);
    logic [PROD_W-1:0] p;
    p = PROD_W'(c) * PROD_W'(lvl);
    return 8'(p >> FADE_LOG2);
  endfunction

  assign Red   = s3_blank ? scale(pal_q[23:16], level) : 8'd0;
  assign Green = s3_blank ? scale(pal_q[15:8],  level) : 8'd0;
  assign Blue  = s3_blank ? scale(pal_q[7:0],   level) : 8'd0;

endmodule

// File: tb/tb_pixel_compositor.sv
// tb/tb_pixel_compositor.sv - directed table-driven bench for pixel_compositor
module tb_pixel_compositor;

  logic        Clk = 1'b0;
  logic        Reset, Blank, FrameStart, MapReq;
  logic [9:0]  DrawX, DrawY;
  logic [23:0] LayerIdx;
  logic [1:0]  MapSel;
  logic        MapAck, Busy;
  logic [1:0]  CurMap;
  logic [7:0]  Red, Green, Blue;
  logic [23:0] rgb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  pixel_compositor dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Blank      (Blank),
    .FrameStart (FrameStart),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .LayerIdx   (LayerIdx),
    .MapReq     (MapReq),
    .MapSel     (MapSel),
    .MapAck     (MapAck),
    .Busy       (Busy),
    .CurMap     (CurMap),
    .Red        (Red),
    .Green      (Green),
    .Blue       (Blue)
  );

  assign rgb = {Red, Green, Blue};

  typedef struct {
    string       name;
    logic        blank;
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] layers;
    logic [23:0] exp_rgb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic frame_pulse(input int n);
    repeat (n) begin
      FrameStart = 1'b1;
      tick(1);
      FrameStart = 1'b0;
      tick(4);
    end
  endtask

  task automatic set_px(input logic b, input logic [9:0] x, input logic [9:0] y, input logic [23:0] l);
    Blank = b; DrawX = x; DrawY = y; LayerIdx = l;
  endtask

  initial begin
    Reset = 1'b1; Blank = 1'b0; FrameStart = 1'b0; MapReq = 1'b0; MapSel = 2'd0;
    DrawX = '0; DrawY = '0; LayerIdx = '0;

    vecs.push_back('{"map5",          1'b1, 10'd85, 10'd5,  24'h000000, 24'hFF8040});
    vecs.push_back('{"map_over_l1",   1'b1, 10'd85, 10'd5,  24'h000240, 24'hFF8040});
    vecs.push_back('{"l0_over_map",   1'b1, 10'd85, 10'd5,  24'h000247, 24'h102030});
    vecs.push_back('{"l1_on_map0",    1'b1, 10'd5,  10'd5,  24'h000240, 24'hA0B0C0});
    vecs.push_back('{"l3_only",       1'b1, 10'd5,  10'd5,  24'h240000, 24'hA0B0C0});
    vecs.push_back('{"l2_over_l3",    1'b1, 10'd5,  10'd5,  24'h247000, 24'h102030});
    vecs.push_back('{"all_transp",    1'b1, 10'd5,  10'd5,  24'h000000, 24'h000000});
    vecs.push_back('{"row1_tile45",   1'b1, 10'd85, 10'd21, 24'h000000, 24'hB54ADD});
    vecs.push_back('{"blanked",       1'b0, 10'd85, 10'd5,  24'h000247, 24'h000000});
`ifdef TILE_GRID_EN
    vecs.push_back('{"grid",          1'b1, 10'd32, 10'd5,  24'h000000, 24'h00FF00});
    vecs.push_back('{"grid_under_l0", 1'b1, 10'd32, 10'd5,  24'h000007, 24'h102030});
    vecs.push_back('{"grid_over_l1",  1'b1, 10'd32, 10'd5,  24'h000240, 24'h00FF00});
`endif

    tick(2);
    check("reset_rgb",    32'(rgb),    32'h0);
    check("reset_ack",    32'(MapAck), 32'h0);
    check("reset_busy",   32'(Busy),   32'h0);
    check("reset_curmap", 32'(CurMap), 32'h0);
    Reset = 1'b0;

    foreach (vecs[i]) begin
      set_px(vecs[i].blank, vecs[i].x, vecs[i].y, vecs[i].layers);
      tick(3);
      check(vecs[i].name, 32'(rgb), 32'(vecs[i].exp_rgb));
    end

    // Blank follows the same three-stage lag as the pixel data.
    set_px(1'b1, 10'd85, 10'd5, 24'h0);
    tick(3);
    check("blank_pre", 32'(rgb), 32'hFF8040);
    Blank = 1'b0;
    tick(2);
    check("blank_lag2", 32'(rgb), 32'hFF8040);
    tick(1);
    check("blank_lag3", 32'(rgb), 32'h0);
    Blank = 1'b1;
    tick(3);

    // Request coincident with FrameStart: accepted, no decrement yet.
    MapReq = 1'b1; MapSel = 2'd2; FrameStart = 1'b1;
    tick(1);
    MapReq = 1'b0; FrameStart = 1'b0;
    check("ack_pulse",  32'(MapAck), 32'h1);
    check("busy_set",   32'(Busy),   32'h1);
    tick(1);
    check("ack_single", 32'(MapAck), 32'h0);
    tick(3);
    check("no_dec_coincident", 32'(rgb), 32'hFF8040);

    frame_pulse(4);
    check("level4_rgb", 32'(rgb), 32'h7F4020);

    MapReq = 1'b1; MapSel = 2'd3;
    tick(1);
    MapReq = 1'b0;
    check("ack_while_busy", 32'(MapAck), 32'h0);
    tick(1);

    frame_pulse(3);
    check("level1_rgb",      32'(rgb),    32'h1F1008);
    check("curmap_hold_out", 32'(CurMap), 32'h0);
    frame_pulse(1);
    check("level0_rgb",      32'(rgb),    32'h0);
    check("busy_at_0",       32'(Busy),   32'h1);
    check("curmap_pre_swap", 32'(CurMap), 32'h0);
    frame_pulse(1);
    check("curmap_swapped",  32'(CurMap), 32'h2);

    set_px(1'b1, 10'd5, 10'd5, 24'h0);
    frame_pulse(4);
    check("fadein_lvl4", 32'(rgb),  32'h403F00);
    frame_pulse(3);
    check("busy_lvl7",   32'(Busy), 32'h1);
    frame_pulse(1);
    check("busy_clear",  32'(Busy), 32'h0);
    check("map2_full",   32'(rgb),  32'h817E00);
    frame_pulse(1);
    check("sat_high",    32'(rgb),  32'h817E00);

    MapReq = 1'b1; MapSel = 2'd2;
    tick(1);
    MapReq = 1'b0;
    check("same_map_ack",  32'(MapAck), 32'h1);
    check("same_map_busy", 32'(Busy),   32'h0);
    tick(1);
    check("same_map_busy2", 32'(Busy),   32'h0);
    check("same_map_cur",   32'(CurMap), 32'h2);

    // Reset in the middle of a fade-in.
    set_px(1'b1, 10'd85, 10'd5, 24'h0);
    MapReq = 1'b1; MapSel = 2'd1;
    tick(1);
    MapReq = 1'b0;
    check("ack_map1", 32'(MapAck), 32'h1);
    frame_pulse(9);
    check("curmap1", 32'(CurMap), 32'h1);
    frame_pulse(3);
    check("map1_lvl3", 32'(rgb), 32'h4F0F1F);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    check("rst_curmap", 32'(CurMap), 32'h0);
    check("rst_busy",   32'(Busy),   32'h0);
    check("rst_rgb",    32'(rgb),    32'h0);
    tick(3);
    check("rst_full_level", 32'(rgb), 32'hFF8040);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
